// File: rtl/example_mul_pkg.sv
// Shared constants and width helper for the saturating pipelined multiplier.
package example_mul_pkg;

    localparam int ROUND_TRUNC   = 0;
    localparam int ROUND_HALF_UP = 1;
    localparam int SAT_WRAP      = 0;
    localparam int SAT_CLAMP     = 1;

    // Width of the product after the optional rounding add and the arithmetic shift.
    function automatic int shifted_width(input int a_w, input int b_w, input int shift, input int rnd);
        return a_w + b_w - shift + (((rnd == ROUND_HALF_UP) && (shift > 0)) ? 1 : 0);
    endfunction

endpackage

// File: rtl/example_mul_sat_rnd.sv
// Combinational round / arithmetic shift / saturate of a full-width signed product.
module example_mul_sat_rnd
    import example_mul_pkg::*;
#(
    parameter int PROD_WIDTH = 26,
    parameter int DOUT_WIDTH = 21,
    parameter int SHIFT      = 0,
    parameter int ROUND      = ROUND_TRUNC,
    parameter int SAT        = SAT_CLAMP
) (
    input  logic signed [PROD_WIDTH-1:0] product,
    output logic signed [DOUT_WIDTH-1:0] res,
    output logic                         res_ovf
);

    localparam int EW  = PROD_WIDTH + 1;
    localparam int SW  = shifted_width(PROD_WIDTH, 0, SHIFT, ROUND);
    localparam int WW  = ((SW > DOUT_WIDTH) ? SW : DOUT_WIDTH) + 1;
    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [EW-1:0] RND_ADD =
        ((ROUND == ROUND_HALF_UP) && (SHIFT > 0)) ? (EW'(1) << RSH) : '0;
    localparam logic signed [WW-1:0] MAX_V =
        {{(WW - DOUT_WIDTH + 1){1'b0}}, {(DOUT_WIDTH - 1){1'b1}}};
    localparam logic signed [WW-1:0] MIN_V = ~MAX_V;

    logic signed [EW-1:0] ext;
    logic signed [SW-1:0] shifted;
    logic signed [WW-1:0] wide;

    // The extra bit in ext absorbs the rounding carry of the most positive product.
    always_comb begin
        ext     = EW'(product) + RND_ADD;
        shifted = SW'(ext >>> SHIFT);
        wide    = WW'(shifted);
        res_ovf = (wide > MAX_V) || (wide < MIN_V);
        if ((SAT == SAT_CLAMP) && res_ovf) begin
            res = wide[WW-1] ? MIN_V[DOUT_WIDTH-1:0] : MAX_V[DOUT_WIDTH-1:0];
        end else begin
            res = wide[DOUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/example_mul_pipe_sat.sv
// Signed multiplier with a globally stalled valid/ready pipeline and round/shift/saturate output.
module example_mul_pipe_sat
    import example_mul_pkg::*;
#(
    parameter int DIN0_WIDTH = 12,
    parameter int DIN1_WIDTH = 14,
    parameter int DOUT_WIDTH = 21,
    parameter int NUM_STAGE  = 2,
    parameter int SHIFT      = 0,
    parameter int ROUND      = ROUND_TRUNC,
    parameter int SAT        = SAT_CLAMP
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic signed [DIN0_WIDTH-1:0] din0,
    input  logic signed [DIN1_WIDTH-1:0] din1,
    input  logic                         in_vld,
    output logic                         in_rdy,
    output logic signed [DOUT_WIDTH-1:0] dout,
    output logic                         ovf,
    output logic                         out_vld,
    input  logic                         out_rdy
);

    localparam int PW = DIN0_WIDTH + DIN1_WIDTH;
    localparam int unsigned NS_U = NUM_STAGE;

    logic                         advance;
    logic                         in_fire;
    logic [NUM_STAGE-1:0]         vld_q, vld_d;
    logic signed [PW-1:0]         prod_c;
    logic signed [PW-1:0]         sat_in;
    logic signed [DOUT_WIDTH-1:0] sat_dout;
    logic                         sat_ovf;
    logic signed [DOUT_WIDTH-1:0] dout_q, dout_d;
    logic                         ovf_q, ovf_d;

    always_comb begin
        advance = !vld_q[NUM_STAGE-1] || out_rdy;
        in_fire = in_vld && advance;
        prod_c  = PW'(din0) * PW'(din1);
        vld_d   = vld_q;
        if (advance) begin
            vld_d[0] = in_fire;
            for (int unsigned i = 1; i < NS_U; i++) begin
                vld_d[i] = vld_q[i-1];
            end
        end
    end

    // vld_d doubles as the per-stage load enable: it is only set when advancing into a valid slot.
    generate
        if (NUM_STAGE == 1) begin : g_direct
            assign sat_in = prod_c;
        end else begin : g_pipe
            localparam int unsigned NP = NS_U - 1;
            logic signed [PW-1:0] prod_q [NP];
            logic signed [PW-1:0] prod_d [NP];

            always_comb begin
                prod_d = prod_q;
                if (advance) begin
                    if (vld_d[0]) prod_d[0] = prod_c;
                    for (int unsigned i = 1; i < NP; i++) begin
                        if (vld_d[i]) prod_d[i] = prod_q[i-1];
                    end
                end
            end

            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    prod_q <= '{default: '0};
                end else begin
                    prod_q <= prod_d;
                end
            end

            assign sat_in = prod_q[NP-1];
        end
    endgenerate

    example_mul_sat_rnd #(
        .PROD_WIDTH (PW),
        .DOUT_WIDTH (DOUT_WIDTH),
        .SHIFT      (SHIFT),
        .ROUND      (ROUND),
        .SAT        (SAT)
    ) u_sat_rnd (
        .product (sat_in),
        .res     (sat_dout),
        .res_ovf (sat_ovf)
    );

    always_comb begin
        dout_d = dout_q;
        ovf_d  = ovf_q;
        if (vld_d[NUM_STAGE-1] && advance) begin
            dout_d = sat_dout;
            ovf_d  = sat_ovf;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            vld_q  <= '0;
            dout_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            dout_q <= dout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign in_rdy  = advance;
    assign out_vld = vld_q[NUM_STAGE-1];
    assign dout    = dout_q;
    assign ovf     = ovf_q;

endmodule
